// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - exhaustive truth-table check engine for small combinational gates
//
// Walks every input vector of a gate under test, holds each one for SETTLE
// cycles, samples the gate output on the following cycle and compares it with
// the expected truth table EXP_TT (bit k = expected output for vector k).
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   level-sampled run request, honoured only when idle
//   stim             out  [N_IN-1:0] vector driven to the gate (MSB = first gate input)
//   dut_out          in   gate output
//   busy             out  high from start acceptance through the done cycle
//   done             out  one-cycle pulse at the end of a run
//   pass             out  last run finished with zero mismatches
//   err_cnt          out  [N_IN:0] mismatch count of the last/current run
//   first_fail_valid out  at least one mismatch recorded in this run
//   first_fail_vec   out  [N_IN-1:0] lowest vector index that mismatched
module gate_truth_checker #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b0111,
  parameter int                   SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  // Settle counter only ever reaches SETTLE-1.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_stim;
  logic [N_IN:0]   r_err_cnt;
  logic            r_ffv;
  logic [N_IN-1:0] r_ffvec;
  logic            r_pass;

  logic            w_mismatch;
  logic            w_last_vec;
  logic [N_IN:0]   w_err_next;

  // Case inequality so an X/Z gate output in simulation scores as a mismatch.
  assign w_mismatch = (dut_out !== EXP_TT[r_stim]);
  assign w_last_vec = (r_stim == VEC_LAST);
  assign w_err_next = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        busy   = 1'b1;
        w_next = w_last_vec ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_stim    <= '0;
      r_err_cnt <= '0;
      r_ffv     <= 1'b0;
      r_ffvec   <= '0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_stim    <= '0;
            r_err_cnt <= '0;
            r_ffv     <= 1'b0;
            r_ffvec   <= '0;
            r_pass    <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
        S_SAMPLE: begin
          r_err_cnt <= w_err_next;
          // Vectors are visited in ascending order, so the first capture is the lowest index.
          if (w_mismatch && !r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_stim;
          end
          if (w_last_vec) begin
            // Verdict must include the sample taken on this very edge.
            r_pass <= (w_err_next == '0);
          end else begin
            r_stim <= r_stim + N_IN'(1);
            r_cnt  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stim             = r_stim;
  assign pass             = r_pass;
  assign err_cnt          = r_err_cnt;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - self-checking bench for gate_truth_checker (NAND2 and XOR3 builds)
module tb_gate_truth_checker;

  logic clk;
  logic rst_n;
  logic st [2];
  logic [7:0] gtt [2];

  int         ni  [2] = '{2, 3};
  int         ps  [2] = '{2, 1};
  logic [7:0] ett [2] = '{8'h07, 8'h96};

  logic [1:0] stim0;
  logic       dout0, busy0, done0, pass0, ffv0;
  logic [2:0] err0;
  logic [1:0] ffvec0;
  logic [2:0] stim1;
  logic       dout1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [2:0] ffvec1;

  // Gate under test: a lookup table indexed by whatever the checker drives.
  assign dout0 = gtt[0][stim0];
  assign dout1 = gtt[1][stim1];

  gate_truth_checker u_nand (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .stim(stim0), .dut_out(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  gate_truth_checker #(.N_IN(3), .EXP_TT(8'h96), .SETTLE(1)) u_xor3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .stim(stim1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_t is the number of edges since start acceptance (-1 = idle).
  int m_t [2], m_stim [2], m_err [2], m_ffv [2], m_ffvec [2], m_pass [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1; m_stim[i] = 0; m_err[i] = 0;
      m_ffv[i] = 0; m_ffvec[i] = 0; m_pass[i] = 0;
    end
  endtask

  task automatic m_step(input int i);
    int p, v, k;
    p = ps[i] + 1;
    v = 1 << ni[i];
    if (m_t[i] < 0) begin
      if (st[i]) begin
        m_t[i] = 0; m_stim[i] = 0; m_err[i] = 0;
        m_ffv[i] = 0; m_ffvec[i] = 0; m_pass[i] = 0;
      end
    end else begin
      m_t[i]++;
      if (m_t[i] == v * p + 1) begin
        m_t[i] = -1;
      end else begin
        if (m_t[i] % p == 0) begin
          k = m_t[i] / p - 1;
          if (gtt[i][k] != ett[i][k]) begin
            m_err[i]++;
            if (m_ffv[i] == 0) begin
              m_ffv[i] = 1;
              m_ffvec[i] = k;
            end
          end
          if (k == v - 1) m_pass[i] = (m_err[i] == 0) ? 1 : 0;
        end
        m_stim[i] = (m_t[i] / p < v - 1) ? m_t[i] / p : v - 1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int v0, v1;
    v0 = (m_t[0] >= 0) ? 1 : 0;
    v1 = (m_t[1] >= 0) ? 1 : 0;
    chk("nand.stim",  int'(stim0),  m_stim[0]);
    chk("nand.busy",  int'(busy0),  v0);
    chk("nand.done",  int'(done0),  (m_t[0] == 4 * 3) ? 1 : 0);
    chk("nand.pass",  int'(pass0),  m_pass[0]);
    chk("nand.err",   int'(err0),   m_err[0]);
    chk("nand.ffv",   int'(ffv0),   m_ffv[0]);
    chk("nand.ffvec", int'(ffvec0), m_ffvec[0]);
    chk("xor3.stim",  int'(stim1),  m_stim[1]);
    chk("xor3.busy",  int'(busy1),  v1);
    chk("xor3.done",  int'(done1),  (m_t[1] == 8 * 2) ? 1 : 0);
    chk("xor3.pass",  int'(pass1),  m_pass[1]);
    chk("xor3.err",   int'(err1),   m_err[1]);
    chk("xor3.ffv",   int'(ffv1),   m_ffv[1]);
    chk("xor3.ffvec", int'(ffvec1), m_ffvec[1]);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_t[0] < 0 && m_t[1] < 0) && n < 100) begin
      tick();
      n++;
    end
    chk("idle_within_budget", (n < 100) ? 1 : 0, 1);
  endtask

  // Pulse start on both checkers; optionally re-pulse at edge extra_at (ignored mid-run).
  task automatic run_both(input int extra_at, output int d0, output int d1);
    int cnt = 0;
    d0 = 0; d1 = 0;
    st[0] = 1'b1; st[1] = 1'b1;
    while ((d0 == 0 || d1 == 0) && cnt < 80) begin
      tick();
      cnt++;
      st[0] = (cnt == extra_at); st[1] = (cnt == extra_at);
      if (done0 && d0 == 0) d0 = cnt;
      if (done1 && d1 == 0) d1 = cnt;
    end
    st[0] = 1'b0; st[1] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int d0, d1, cnt, r;
    rst_n = 1'b0;
    st[0] = 1'b0; st[1] = 1'b0;
    gtt[0] = 8'h07; gtt[1] = 8'h96;
    tick(); tick();
    chk("reset.nand_err", int'(err0), 0);
    chk("reset.xor3_busy", int'(busy1), 0);
    rst_n = 1'b1;
    tick();

    // Correct gates
    run_both(0, d0, d1);
    chk("clean.nand_done_cycle", d0, 13);
    chk("clean.xor3_done_cycle", d1, 17);
    chk("clean.nand_pass", int'(pass0), 1);
    chk("clean.nand_err", int'(err0), 0);
    chk("clean.nand_ffv", int'(ffv0), 0);
    chk("clean.xor3_pass", int'(pass1), 1);

    // Output stuck at 1
    gtt[0] = 8'hFF; gtt[1] = 8'hFF;
    run_both(0, d0, d1);
    chk("stuck1.nand_err", int'(err0), 1);
    chk("stuck1.nand_ffv", int'(ffv0), 1);
    chk("stuck1.nand_ffvec", int'(ffvec0), 3);
    chk("stuck1.nand_pass", int'(pass0), 0);
    chk("stuck1.xor3_err", int'(err1), 4);

    // Inverted gates (AND in place of NAND, XNOR3 in place of XOR3)
    gtt[0] = 8'h08; gtt[1] = 8'h69;
    run_both(0, d0, d1);
    chk("inv.nand_err", int'(err0), 4);
    chk("inv.nand_ffvec", int'(ffvec0), 0);
    chk("inv.nand_pass", int'(pass0), 0);
    chk("inv.xor3_err", int'(err1), 8);

    // Extra start pulse mid-run is ignored
    gtt[0] = 8'hFF;
    run_both(5, d0, d1);
    chk("restart.nand_done_cycle", d0, 13);
    chk("restart.nand_err", int'(err0), 1);
    chk("restart.nand_ffvec", int'(ffvec0), 3);

    // Start held high: re-run after exactly one idle cycle, err_cnt cleared then
    st[0] = 1'b1; st[1] = 1'b1;
    for (cnt = 1; cnt <= 15; cnt++) begin
      tick();
      if (cnt == 13) chk("hold.nand_done", int'(done0), 1);
      if (cnt == 14) begin
        chk("hold.nand_idle_busy", int'(busy0), 0);
        chk("hold.nand_err_held", int'(err0), 1);
      end
      if (cnt == 15) begin
        chk("hold.nand_busy_again", int'(busy0), 1);
        chk("hold.nand_err_cleared", int'(err0), 0);
      end
    end
    st[0] = 1'b0; st[1] = 1'b0;
    wait_idle();

    // Reset while vector 2 is driving
    gtt[0] = 8'h08;
    st[0] = 1'b1; st[1] = 1'b1;
    for (cnt = 1; cnt <= 7; cnt++) begin
      tick();
      st[0] = 1'b0; st[1] = 1'b0;
    end
    chk("midrst.nand_err_before", int'(err0), 2);
    chk("midrst.nand_stim_before", int'(stim0), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.nand_busy", int'(busy0), 0);
    chk("midrst.nand_err", int'(err0), 0);
    chk("midrst.nand_stim", int'(stim0), 0);
    chk("midrst.nand_ffv", int'(ffv0), 0);
    tick();
    rst_n = 1'b1;
    gtt[0] = 8'h07; gtt[1] = 8'h96;
    run_both(0, d0, d1);
    chk("postrst.nand_done_cycle", d0, 13);
    chk("postrst.nand_pass", int'(pass0), 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_t[i] < 0) begin
          if (!st[i]) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) gtt[i] = ett[i];
            else if (r == 1) gtt[i] = ett[i] ^ (8'h01 << $urandom_range(0, 7));
            else gtt[i] = 8'($urandom);
          end
          st[i] = ($urandom_range(0, 3) != 0);
        end else begin
          st[i] = ($urandom_range(0, 7) == 0);
        end
      end
    end
    st[0] = 1'b0; st[1] = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Synthesizable exhaustive stimulus-and-check engine for small combinational gates (the NAND/NOR/XOR family blocks). On `start` it drives every input vector to the gate under test, waits a programmable settle time, and samples the gate output. It compares each sample against a parameterized truth table and reports a pass/fail summary with an error count and the first failing vector. It sits beside a gate instance on FPGA/bring-up builds and replaces manual waveform inspection.

## Interface

Parameters:
- `N_IN`, 2, number of gate inputs (1..6)
- `EXP_TT`, 4'b0111, expected truth table, width 2^N_IN; bit k = expected output for input vector k (default = 2-input NAND)
- `SETTLE`, 2, cycles stim is held before the sample cycle (>=1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  level-sampled run request; accepted only in IDLE
- `stim`  out  N_IN  registered input vector to the gate; MSB = first gate input
- `dut_out`  in  1  gate output
- `busy`  out  1  high from start acceptance until done cycle inclusive
- `done`  out  1  single-cycle pulse at end of run
- `pass`  out  1  1 when last run had zero mismatches
- `err_cnt`  out  N_IN+1  mismatch count of last/current run (max 2^N_IN)
- `first_fail_valid`  out  1  at least one mismatch recorded this run
- `first_fail_vec`  out  N_IN  lowest vector index that mismatched

## Operation

- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: `start`=1 at edge -> DRIVE; `stim`<=0, settle counter<=0, `err_cnt`<=0, `first_fail_valid`<=0, `first_fail_vec`<=0, `pass`<=0, `busy`<=1.
- DRIVE: counter increments each edge; at edge where counter==SETTLE-1 -> SAMPLE. `stim` constant.
- SAMPLE: at next edge compare `dut_out` with `EXP_TT[stim]`. Mismatch: `err_cnt`+=1; if `first_fail_valid`==0, capture `first_fail_vec`<=`stim`, `first_fail_valid`<=1. Then: if `stim`==2^N_IN-1 -> DONE, else `stim`+=1, counter<=0, -> DRIVE.
- DONE: `done`=1, `busy`=1 for one cycle; `pass`<=(`err_cnt`==0) at entry to DONE (uses count including final sample); next edge -> IDLE, `busy`<=0.
- `start` in DRIVE/SAMPLE/DONE ignored; no queuing. `start` held high continuously re-runs after exactly one IDLE cycle.
- After run, `stim`, `pass`, `err_cnt`, `first_fail_*` hold until the next accepted `start`.
- X/Z on `dut_out` in simulation counts as mismatch (case-inequality compare).
- `stim` wrap never occurs: last vector terminates the run; `err_cnt` cannot overflow (width N_IN+1).

## Timing

- Reset (async, any state, mid-run included): state IDLE, `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail_valid`=0, `first_fail_vec`=0, counter=0. Run is abandoned, not resumed.
- Edge e0 samples `start`; `stim`=0 visible after e0.
- Each vector occupies SETTLE+1 cycles; vector k sampled at edge e((k+1)(SETTLE+1)).
- Last sample at e(2^N_IN*(SETTLE+1)) -> DONE; `done` high for the following cycle; `busy` low after e(2^N_IN*(SETTLE+1)+1).
- Defaults (N_IN=2, SETTLE=2): sample edges e3,e6,e9,e12; `done` high between e12 and e13.
- Gate output must be stable within SETTLE cycles of `stim` change; combinational gate needs SETTLE>=1.

## Test plan

- Correct NAND, defaults, pulse `start` -> `stim` 0,1,2,3 each held 3 cycles; `done` one cycle after e12; `pass`=1, `err_cnt`=0, `first_fail_valid`=0.
- `dut_out` stuck at 1 -> `err_cnt`=1, `first_fail_valid`=1, `first_fail_vec`=3, `pass`=0.
- AND gate substituted (all outputs inverted) -> `err_cnt`=4, `first_fail_vec`=0, `pass`=0.
- `start` pulsed again at e5 of a run -> ignored; run still ends at e12 with unchanged results; `start` held high -> second run's e0 is one cycle after DONE, `err_cnt` cleared at that edge.
- `rst_n` low at e7 (vector 2 driving) -> all outputs 0 immediately, state IDLE; fresh `start` yields full clean run.
- N_IN=3, EXP_TT=8'h96 (XOR3), SETTLE=1, correct XOR3 -> 8 vectors, samples every 2 cycles, `done` after e16, `pass`=1.
